// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style memory bus between the fetch and data ports.
// Bus strobes are registered and held across waitrequest; a watchdog aborts stalled accesses.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteenable,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] WdLimit = CntW'(TIMEOUT_CYCLES);
    localparam logic OwnerI = 1'b0;
    localparam logic OwnerD = 1'b1;

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [31:0]     address_q, address_d;
    logic [31:0]     writedata_q, writedata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [3:0]      byteenable_q, byteenable_d;
    logic            read_q, read_d;
    logic            write_q, write_d;
    logic            err_q, err_d;
    logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
    logic            grant_fetch, grant_data;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        rdata_d      = rdata_q;
        byteenable_d = byteenable_q;
        read_d       = read_q;
        write_d      = write_q;
        err_d        = err_q;
        wd_cnt_d     = wd_cnt_q;
        grant_fetch  = 1'b0;
        grant_data   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // On a tie the requester that was not served last wins.
                grant_fetch = i_req & (~d_req | (last_q == OwnerD));
                grant_data  = d_req & (~i_req | (last_q == OwnerI));
                if (grant_fetch) begin
                    state_d      = StBus;
                    owner_d      = OwnerI;
                    address_d    = i_addr & 32'hffff_fffc;
                    writedata_d  = '0;
                    byteenable_d = 4'b1111;
                    read_d       = 1'b1;
                    write_d      = 1'b0;
                end else if (grant_data) begin
                    state_d      = StBus;
                    owner_d      = OwnerD;
                    address_d    = d_addr & 32'hffff_fffc;
                    writedata_d  = d_wdata;
                    byteenable_d = d_byteenable;
                    read_d       = ~d_we;
                    write_d      = d_we;
                end
                rdata_d  = '0;
                err_d    = 1'b0;
                wd_cnt_d = '0;
            end
            StBus: begin
                if (!waitrequest) begin
                    rdata_d = read_q ? readdata : '0;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = StResp;
                end else if ((TIMEOUT_CYCLES != 0) && (wd_cnt_q == WdLimit)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = StResp;
                end else if (TIMEOUT_CYCLES != 0) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            StResp: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            owner_q      <= OwnerI;
            last_q       <= OwnerD;
            address_q    <= '0;
            writedata_q  <= '0;
            rdata_q      <= '0;
            byteenable_q <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            wd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            rdata_q      <= rdata_d;
            byteenable_q <= byteenable_d;
            read_q       <= read_d;
            write_q      <= write_d;
            err_q        <= err_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

    assign i_ack   = (state_q == StResp) && (owner_q == OwnerI);
    assign d_ack   = (state_q == StResp) && (owner_q == OwnerD);
    assign i_err   = i_ack & err_q;
    assign d_err   = d_ack & err_q;
    assign i_rdata = i_ack ? rdata_q : '0;
    assign d_rdata = d_ack ? rdata_q : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised scoreboard bench for mem_bus_arbiter: requester agents push expected transactions,
// a bus slave stalls by an address-derived count, and a monitor checks bus and responses.
module tb_mem_bus_arbiter;
    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req, d_req, d_we, waitrequest;
    logic [31:0] i_addr, d_addr, d_wdata, readdata;
    logic [3:0]  d_byteenable;
    logic [31:0] i_rdata, d_rdata, address, writedata;
    logic        i_ack, i_err, d_ack, d_err, read, write;
    logic [3:0]  byteenable;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byteenable(d_byteenable), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t q_i[$];
    txn_t q_d[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_busy = 1'b0;
    logic mon_owner = 1'b0;  // 0 = fetch, 1 = data
    logic i_pend = 1'b0, d_pend = 1'b0;
    logic rst_at_edge = 1'b1;

    always @(posedge clk) rst_at_edge <= !reset_n;

    // Memory contents seen by the slave: a fixed scramble of the word address.
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // Wait states the slave inserts are encoded in address bits [5:3].
    function automatic int waits_of(input logic [31:0] a);
        return int'(a[5:3]);
    endfunction

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bus slave: stalls each access by waits_of(address) cycles, junk data while stalled.
    initial begin
        int s_cnt;
        s_cnt = 0;
        waitrequest = 1'b1;
        readdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (read || write) begin
                waitrequest = (s_cnt < waits_of(address));
                readdata = (!waitrequest && read) ? rd_fn(address) : $urandom();
                s_cnt++;
            end else begin
                s_cnt = 0;
                waitrequest = 1'($urandom_range(0, 1));
                readdata = $urandom();
            end
        end
    end

    // Monitor: arbitration rule, held bus fields, response latency and contents.
    logic prev_i = 1'b0, prev_d = 1'b0, prev_idle = 1'b0, last = 1'b1;
    logic strobe, ack_cycle, exp_err;
    logic [31:0] exp_rd;
    txn_t cur;
    int ncyc = 0, exp_len = 0, qsize;

    always @(negedge clk) begin
        strobe = read | write;
        ack_cycle = 1'b0;
        if (rst_at_edge) begin
            check("reset_outputs", 192'({read, write, address, writedata, byteenable, i_ack,
                  i_err, i_rdata, d_ack, d_err, d_rdata}), 192'(0));
            mon_busy = 1'b0;
            last = 1'b1;
        end else begin
            if (!mon_busy) begin
                check("grant_timing", 192'({strobe, i_ack, d_ack}),
                      192'({prev_idle && (prev_i || prev_d), 2'b00}));
                if (strobe && prev_idle && (prev_i || prev_d)) begin
                    mon_owner = (prev_i && prev_d) ? ~last : prev_d;
                    qsize = mon_owner ? q_d.size() : q_i.size();
                    check("grant_txn", 192'(qsize != 0), 192'(1));
                    if (qsize != 0) begin
                        cur = mon_owner ? q_d[0] : q_i[0];
                        mon_busy = 1'b1;
                        ncyc = 0;
                        exp_err = waits_of(cur.addr) > int'(T);
                        exp_len = exp_err ? int'(T) + 1 : waits_of(cur.addr) + 1;
                        exp_rd = (exp_err || cur.we) ? 32'h0 : rd_fn({cur.addr[31:2], 2'b00});
                    end
                end
            end
            if (mon_busy) begin
                if (strobe) begin
                    ncyc++;
                    check("bus_hold", 192'({address, read, write, byteenable,
                          cur.we ? writedata : 32'h0, i_ack, d_ack}),
                          192'({cur.addr[31:2], 2'b00, ~cur.we, cur.we, cur.be,
                          cur.we ? cur.wdata : 32'h0, 2'b00}));
                    check("stall_len", 192'(ncyc <= exp_len), 192'(1));
                    if (ncyc > exp_len) begin
                        if (mon_owner) void'(q_d.pop_front());
                        else void'(q_i.pop_front());
                        mon_busy = 1'b0;
                    end
                end else begin
                    ack_cycle = 1'b1;
                    check("resp_latency", 192'(ncyc), 192'(exp_len));
                    check("resp", 192'({i_ack, i_err, i_rdata, d_ack, d_err, d_rdata}),
                          mon_owner ? 192'({1'b0, 1'b0, 32'h0, 1'b1, exp_err, exp_rd})
                                    : 192'({1'b1, exp_err, exp_rd, 1'b0, 1'b0, 32'h0}));
                    if (mon_owner) void'(q_d.pop_front());
                    else void'(q_i.pop_front());
                    last = mon_owner;
                    mon_busy = 1'b0;
                end
            end
        end
        prev_idle = !mon_busy && !ack_cycle && reset_n;
        prev_i = i_req;
        prev_d = d_req;
    end

    function automatic int pick_w();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5) return 0;
        if (r < 8) return $urandom_range(1, 4);
        return $urandom_range(5, 7);
    endfunction

    task automatic issue_i(input int w);
        txn_t t;
        t.we = 1'b0;
        t.addr = $urandom();
        t.addr[5:3] = 3'(w);
        t.wdata = 32'h0;
        t.be = 4'b1111;
        i_addr = t.addr;
        i_req = 1'b1;
        i_pend = 1'b1;
        q_i.push_back(t);
    endtask

    task automatic issue_d(input int w);
        txn_t t;
        t.we = 1'($urandom_range(0, 1));
        t.addr = $urandom();
        t.addr[5:3] = 3'(w);
        t.wdata = $urandom();
        t.be = 4'($urandom_range(0, 15));
        d_we = t.we;
        d_addr = t.addr;
        d_wdata = t.wdata;
        d_byteenable = t.be;
        d_req = 1'b1;
        d_pend = 1'b1;
        q_d.push_back(t);
    endtask

    // One cycle of both requester agents; the owner scrambles its inputs while being served.
    task automatic step(input int rate);
        @(posedge clk);
        #1;
        if (i_pend && i_ack) i_pend = 1'b0;
        if (d_pend && d_ack) d_pend = 1'b0;
        if (!i_pend) begin
            if ($urandom_range(0, 99) < rate) issue_i(pick_w());
            else i_req = 1'b0;
        end else if (mon_busy && !mon_owner) begin
            i_addr = $urandom();
        end
        if (!d_pend) begin
            if ($urandom_range(0, 99) < rate) issue_d(pick_w());
            else d_req = 1'b0;
        end else if (mon_busy && mon_owner) begin
            d_we = 1'($urandom_range(0, 1));
            d_addr = $urandom();
            d_wdata = $urandom();
            d_byteenable = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((i_pend || d_pend || mon_busy) && n < 2000) begin
            step(0);
            n++;
        end
        check("drain_done", 192'({i_pend, d_pend, mon_busy}), 192'(0));
    endtask

    initial begin
        int n;
        i_req = 1'b0;
        i_addr = 32'h0;
        d_req = 1'b0;
        d_we = 1'b0;
        d_addr = 32'h0;
        d_wdata = 32'h0;
        d_byteenable = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int k = 0; k < 3000; k++) step(k < 1000 ? 25 : (k < 2000 ? 100 : 60));
        drain();

        // Abandon a stalled fetch with reset, then a tie must go to fetch first.
        @(posedge clk);
        #1;
        issue_i(7);
        n = 0;
        while (!mon_busy && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reset_test_grant", 192'(mon_busy), 192'(1));
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        q_i.delete();
        q_d.delete();
        i_pend = 1'b0;
        d_pend = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        issue_i(0);
        issue_d(2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got still running, expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
